piece_motion_ctrl: RTL and testbench

Active-piece motion controller for the Tetris playfield. It owns the falling piece's shape number, rotation and top-left pixel position. It drives `shape_num`/`shape_rot` into the block-size lookup and reads the returned `shape_size_x`/`shape_size_y` back to bound-check moves, rotations and gravity. Downstream, the sprite renderer consumes its position/shape outputs, and the board-merge logic consumes its `landed` pulse.

---
 rtl/piece_motion_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_piece_motion_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_motion_ctrl.sv
// piece_motion_ctrl
// Owns the falling Tetris piece: shape number, rotation and top-left pixel
// position. It moves the piece left/right on key edges, rotates it with a
// one-cycle bound check, and applies gravity from frame ticks until the piece
// can no longer fall. Then it pulses landed for one cycle.
//
// Ports
//   Clk, Reset          clock, asynchronous active-high reset
//   frame_tick          one-cycle pulse per video frame
//   spawn, spawn_shape  request to start a new piece of shape 1..7
//   key_left/right/rot  synchronised level keys, acted on at their rising edge
//   key_down            level key, selects the soft-drop fall rate
//   shape_size_x/y      piece size in pixels for the current shape_num/shape_rot
//   shape_num/shape_rot current shape (0 = none) and rotation
//   pos_x, pos_y        piece top-left pixel
//   active              high while a piece is falling (FALL or ROT_CHECK)
//   landed              one-cycle pulse when the piece locks
module piece_motion_ctrl #(
  parameter int unsigned CELL           = 16,
  parameter int unsigned FIELD_X_MIN    = 240,
  parameter int unsigned FIELD_X_MAX    = 400,
  parameter int unsigned FIELD_Y_MIN    = 0,
  parameter int unsigned FIELD_Y_MAX    = 320,
  parameter int unsigned SPAWN_X        = 304,
  parameter int unsigned GRAVITY_FRAMES = 30,
  parameter int unsigned SOFT_FRAMES    = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       spawn,
  input  logic [2:0] spawn_shape,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_rot,
  input  logic       key_down,
  input  logic [9:0] shape_size_x,
  input  logic [9:0] shape_size_y,
  output logic [2:0] shape_num,
  output logic [1:0] shape_rot,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       active,
  output logic       landed
);

  localparam int unsigned POS_W   = 10;
  localparam int unsigned SUM_W   = 11;
  localparam int unsigned CNT_MAX = (GRAVITY_FRAMES > SOFT_FRAMES) ? GRAVITY_FRAMES : SOFT_FRAMES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FALL      = 2'd1,
    ROT_CHECK = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  grav_cnt;
  logic [1:0]        rot_saved;
  logic              left_q;
  logic              right_q;
  logic              rot_q;

  logic              left_edge;
  logic              right_edge;
  logic              rot_edge;
  logic [SUM_W-1:0]  x_ext;
  logic [SUM_W-1:0]  x_far;
  logic [SUM_W-1:0]  y_far;
  logic              can_left;
  logic              can_right;
  logic              can_fall;
  logic              rot_fits;
  logic [CNT_W:0]    cnt_inc;
  logic [CNT_W:0]    fall_thr;
  logic              step_due;
  logic [POS_W-1:0]  x_moved;

  // Rising edges of the move/rotate keys
  assign left_edge  = key_left  & ~left_q;
  assign right_edge = key_right & ~right_q;
  assign rot_edge   = key_rot   & ~rot_q;

  // Bound sums, one bit wider than the position so nothing wraps
  assign x_ext = {1'b0, pos_x};
  assign x_far = x_ext + {1'b0, shape_size_x};
  assign y_far = {1'b0, pos_y} + {1'b0, shape_size_y};

  // pos_x - CELL >= FIELD_X_MIN, rearranged to avoid an underflowing subtraction
  assign can_left  = x_ext >= SUM_W'(FIELD_X_MIN + CELL);
  assign can_right = (x_far + SUM_W'(CELL)) <= SUM_W'(FIELD_X_MAX);
  assign can_fall  = (y_far + SUM_W'(CELL)) <= SUM_W'(FIELD_Y_MAX);
  assign rot_fits  = (x_far <= SUM_W'(FIELD_X_MAX)) && (y_far <= SUM_W'(FIELD_Y_MAX));

  // Gravity: a step is due on the tick that brings the count to the threshold
  assign cnt_inc  = {1'b0, grav_cnt} + (CNT_W + 1)'(1);
  assign fall_thr = key_down ? (CNT_W + 1)'(SOFT_FRAMES) : (CNT_W + 1)'(GRAVITY_FRAMES);
  assign step_due = frame_tick && (cnt_inc >= fall_thr);

  // Horizontal candidate; opposing edges in the same cycle cancel
  always_comb begin
    x_moved = pos_x;
    if (left_edge && !right_edge && can_left) begin
      x_moved = pos_x - POS_W'(CELL);
    end else if (right_edge && !left_edge && can_right) begin
      x_moved = pos_x + POS_W'(CELL);
    end
  end

  // Motion FSM with registered outputs
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      shape_num <= 3'd0;
      shape_rot <= 2'd0;
      rot_saved <= 2'd0;
      pos_x     <= POS_W'(SPAWN_X);
      pos_y     <= POS_W'(FIELD_Y_MIN);
      active    <= 1'b0;
      landed    <= 1'b0;
      grav_cnt  <= '0;
      left_q    <= 1'b0;
      right_q   <= 1'b0;
      rot_q     <= 1'b0;
    end else begin
      // Key history tracks every cycle so a key held across a spawn is not an edge
      left_q  <= key_left;
      right_q <= key_right;
      rot_q   <= key_rot;
      landed  <= 1'b0;

      case (state)
        IDLE: begin
          if (spawn && (spawn_shape != 3'd0)) begin
            shape_num <= spawn_shape;
            shape_rot <= 2'd0;
            pos_x     <= POS_W'(SPAWN_X);
            pos_y     <= POS_W'(FIELD_Y_MIN);
            grav_cnt  <= '0;
            active    <= 1'b1;
            state     <= FALL;
          end
        end

        FALL: begin
          if (rot_edge) begin
            // Rotation wins the cycle: moves are discarded and the tick is dropped
            rot_saved <= shape_rot;
            shape_rot <= shape_rot + 2'd1;
            state     <= ROT_CHECK;
          end else begin
            pos_x <= x_moved;
            if (frame_tick) begin
              if (step_due) begin
                grav_cnt <= '0;
                if (can_fall) begin
                  pos_y <= pos_y + POS_W'(CELL);
                end else begin
                  // Lock in place; shape and position hold for the merge logic
                  landed <= 1'b1;
                  active <= 1'b0;
                  state  <= IDLE;
                end
              end else begin
                grav_cnt <= grav_cnt + CNT_W'(1);
              end
            end
          end
        end

        ROT_CHECK: begin
          // Size inputs now describe the new rotation; undo it if it overhangs
          if (!rot_fits) begin
            shape_rot <= rot_saved;
          end
          state <= FALL;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piece_motion_ctrl.sv
// Bench for piece_motion_ctrl: directed scenarios with literal expectations,
// then randomized stimulus, all checked every cycle against a rule-level model.
module tb_piece_motion_ctrl;

  localparam int CELL  = 16;
  localparam int XMIN  = 240;
  localparam int XMAX  = 400;
  localparam int YMIN  = 0;
  localparam int YMAX  = 320;
  localparam int SPX   = 304;
  localparam int GRAV  = 30;
  localparam int SOFT  = 3;

  logic       Clk;
  logic       Reset;
  logic       ft, sp, kl, kr, krt, kd;
  logic [2:0] ssh;
  logic [9:0] shape_size_x, shape_size_y;
  logic [2:0] shape_num;
  logic [1:0] shape_rot;
  logic [9:0] pos_x, pos_y;
  logic       active, landed;

  int total = 0;
  int bad   = 0;

  // Shape sizes: 1 = I (64x16 / 16x64), 2 = O (32x32), 3..7 = 48x32 / 32x48
  function automatic int lut_w(input int s, input int r);
    if (s == 0) return 0;
    if (s == 1) return (r % 2) ? 16 : 64;
    if (s == 2) return 32;
    return (r % 2) ? 32 : 48;
  endfunction

  function automatic int lut_h(input int s, input int r);
    if (s == 0) return 0;
    if (s == 1) return (r % 2) ? 64 : 16;
    if (s == 2) return 32;
    return (r % 2) ? 48 : 32;
  endfunction

  assign shape_size_x = 10'(lut_w(int'(shape_num), int'(shape_rot)));
  assign shape_size_y = 10'(lut_h(int'(shape_num), int'(shape_rot)));

  piece_motion_ctrl dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_tick   (ft),
    .spawn        (sp),
    .spawn_shape  (ssh),
    .key_left     (kl),
    .key_right    (kr),
    .key_rot      (krt),
    .key_down     (kd),
    .shape_size_x (shape_size_x),
    .shape_size_y (shape_size_y),
    .shape_num    (shape_num),
    .shape_rot    (shape_rot),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .active       (active),
    .landed       (landed)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: piece state plus "falling" and "checking rotation" flags
  int m_shape, m_rot, m_old, m_x, m_y, m_cnt;
  bit m_fall, m_chk, m_land;
  bit pl, pr, prt;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_shape <= 0; m_rot <= 0; m_old <= 0; m_x <= SPX; m_y <= YMIN; m_cnt <= 0;
      m_fall <= 0; m_chk <= 0; m_land <= 0; pl <= 0; pr <= 0; prt <= 0;
    end else begin
      pl <= kl; pr <= kr; prt <= krt; m_land <= 0;
      if (m_chk) begin
        if (m_x + lut_w(m_shape, m_rot) > XMAX || m_y + lut_h(m_shape, m_rot) > YMAX)
          m_rot <= m_old;
        m_chk <= 0;
      end else if (m_fall) begin
        if (krt && !prt) begin
          m_old <= m_rot;
          m_rot <= (m_rot + 1) % 4;
          m_chk <= 1;
        end else begin
          if ((kl && !pl) && !(kr && !pr) && (m_x - CELL >= XMIN))
            m_x <= m_x - CELL;
          else if ((kr && !pr) && !(kl && !pl) && (m_x + lut_w(m_shape, m_rot) + CELL <= XMAX))
            m_x <= m_x + CELL;
          if (ft) begin
            if (m_cnt + 1 >= (kd ? SOFT : GRAV)) begin
              m_cnt <= 0;
              if (m_y + lut_h(m_shape, m_rot) + CELL <= YMAX) m_y <= m_y + CELL;
              else begin
                m_land <= 1;
                m_fall <= 0;
              end
            end else begin
              m_cnt <= m_cnt + 1;
            end
          end
        end
      end else if (sp && ssh != 3'd0) begin
        m_shape <= int'(ssh); m_rot <= 0; m_x <= SPX; m_y <= YMIN; m_cnt <= 0; m_fall <= 1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge Clk) begin
    if (!Reset) begin
      total++;
      if ({shape_num, shape_rot, pos_x, pos_y, active, landed} !==
          {3'(m_shape), 2'(m_rot), 10'(m_x), 10'(m_y), m_fall, m_land}) begin
        bad++;
        $display("FAIL model t=%0t dut shp=%0d rot=%0d x=%0d y=%0d act=%0b land=%0b want shp=%0d rot=%0d x=%0d y=%0d act=%0b land=%0b",
                 $time, shape_num, shape_rot, pos_x, pos_y, active, landed,
                 m_shape, m_rot, m_x, m_y, m_fall, m_land);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clr();
    kl = 0; kr = 0; krt = 0; ft = 0; sp = 0;
  endtask

  task automatic cyc();
    @(negedge Clk);
  endtask

  task automatic do_reset();
    clr(); Reset = 1; cyc(); Reset = 0; cyc();
  endtask

  task automatic do_spawn(input logic [2:0] s);
    clr(); sp = 1; ssh = s; cyc(); sp = 0;
  endtask

  // 0 = left, 1 = right, 2 = rotate; key high one cycle then low one cycle
  task automatic press(input int k);
    clr();
    case (k)
      0: kl = 1;
      1: kr = 1;
      default: krt = 1;
    endcase
    cyc(); clr(); cyc();
  endtask

  task automatic ticks(input int n);
    repeat (n) begin ft = 1; cyc(); end
    ft = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1; clr(); kd = 0; ssh = 3'd0;
    repeat (2) cyc();
    Reset = 0; cyc();

    // Reset values
    chk("rst_shape", int'(shape_num), 0);
    chk("rst_x", int'(pos_x), 304);
    chk("rst_y", int'(pos_y), 0);
    chk("rst_active", int'(active), 0);
    chk("rst_landed", int'(landed), 0);

    // Shape 0 spawn is ignored
    do_spawn(3'd0);
    chk("spawn0_active", int'(active), 0);

    // Spawn I and first gravity step after 30 ticks
    do_spawn(3'd1);
    chk("spawn_shape", int'(shape_num), 1);
    chk("spawn_rot", int'(shape_rot), 0);
    chk("spawn_x", int'(pos_x), 304);
    chk("spawn_y", int'(pos_y), 0);
    chk("spawn_active", int'(active), 1);
    ticks(29);
    chk("grav29_y", int'(pos_y), 0);
    ticks(1);
    chk("grav30_y", int'(pos_y), 16);

    // O piece: right wall, opposing edges, left wall
    do_reset();
    do_spawn(3'd2);
    repeat (6) press(1);
    chk("o_right_wall", int'(pos_x), 368);
    clr(); kl = 1; kr = 1; cyc(); clr(); cyc();
    chk("o_left_right", int'(pos_x), 368);
    repeat (10) press(0);
    chk("o_left_wall", int'(pos_x), 240);

    // O soft drop to the floor, spawn ignored mid-fall, then landing
    kd = 1;
    ticks(54);
    chk("o_y288", int'(pos_y), 288);
    do_spawn(3'd5);
    chk("o_spawn_ign", int'(shape_num), 2);
    ticks(2);
    chk("o_y_hold", int'(pos_y), 288);
    ft = 1; cyc(); ft = 0;
    chk("o_landed", int'(landed), 1);
    chk("o_land_active", int'(active), 0);
    chk("o_land_y", int'(pos_y), 288);
    cyc();
    chk("o_landed_off", int'(landed), 0);
    kd = 0;

    // I piece rotations near walls
    do_reset();
    do_spawn(3'd1);
    press(2);
    chk("i_rot1", int'(shape_rot), 1);
    repeat (6) press(1);
    chk("i_vert_right", int'(pos_x), 384);
    clr(); krt = 1; cyc();
    chk("i_rot_try", int'(shape_rot), 2);
    clr(); cyc();
    chk("i_rot_revert", int'(shape_rot), 1);
    repeat (10) press(0);
    chk("i_vert_left", int'(pos_x), 240);
    press(2);
    chk("i_rot2_kept", int'(shape_rot), 2);
    press(1);
    clr(); krt = 1; kl = 1; cyc();
    chk("rotleft_x", int'(pos_x), 256);
    chk("rotleft_rot", int'(shape_rot), 3);
    clr(); cyc();
    chk("rotleft_kept", int'(shape_rot), 3);
    press(2);
    chk("i_rot0", int'(shape_rot), 0);
    kd = 1;
    ticks(57);
    kd = 0;
    chk("i_y304", int'(pos_y), 304);
    clr(); krt = 1; cyc();
    chk("i_floor_try", int'(shape_rot), 1);
    clr(); cyc();
    chk("i_floor_revert", int'(shape_rot), 0);

    // Asynchronous reset while checking a rotation
    clr(); krt = 1; cyc();
    chk("rc_rot", int'(shape_rot), 1);
    #1 Reset = 1;
    #1;
    chk("rc_rst_shape", int'(shape_num), 0);
    chk("rc_rst_active", int'(active), 0);
    chk("rc_rst_landed", int'(landed), 0);
    chk("rc_rst_rot", int'(shape_rot), 0);
    clr(); cyc();
    Reset = 0; cyc();
    chk("rc_after_landed", int'(landed), 0);
    chk("rc_after_active", int'(active), 0);

    // Randomized phase, checked by the every-cycle model compare
    for (int i = 0; i < 4000; i++) begin
      kl  = ($urandom_range(0, 3) == 0);
      kr  = ($urandom_range(0, 3) == 0);
      krt = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 15) == 0) kd = ~kd;
      ft  = ($urandom_range(0, 1) == 1);
      sp  = ($urandom_range(0, 19) == 0);
      ssh = 3'($urandom_range(0, 7));
      cyc();
    end
    clr();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
